// File: rtl/mem_access_unit_if.sv
// Request/response and data_memory signal bundle for mem_access_unit.
// slave: the access unit; master: the pipeline and data_memory side driving it.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        load;
  logic        store;
  logic [1:0]  size;
  logic        load_unsigned;
  logic [31:0] address;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        load_valid;
  logic        align_error;
  logic        range_error;
  logic [31:0] error_addr;
  logic [31:0] dm_address;
  logic [31:0] dm_data;
  logic        dm_write;
  logic        dm_read;
  logic [31:0] dm_read_data;

  modport slave (
    input  req_valid, load, store, size, load_unsigned, address, store_data, dm_read_data,
    output req_ready, load_data, load_valid, align_error, range_error, error_addr,
           dm_address, dm_data, dm_write, dm_read
  );

  modport master (
    output req_valid, load, store, size, load_unsigned, address, store_data, dm_read_data,
    input  req_ready, load_data, load_valid, align_error, range_error, error_addr,
           dm_address, dm_data, dm_write, dm_read
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store front-end: byte/half/word accesses onto a word-only data_memory,
// sub-word stores by read-modify-write. Optional address range check: MEM_ACCESS_RANGE_CHECK_EN.
module mem_access_unit #(
  parameter bit          BIG_ENDIAN     = 1'b1,
  parameter int unsigned ENTRY_NUM_LOG2 = 7
) (
  input  logic            clock_i,
  input  logic            reset_i,
  mem_access_unit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, RESP} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        store_q;
  logic        range_flag;

  logic        is_mem;
  logic        bad_shape;
  logic        illegal;
  logic        out_of_range;
  logic [4:0]  shift;
  logic [31:0] lane_word;
  logic [31:0] lane_mask;
  logic [31:0] load_ext;
  logic [31:0] merged;

  // Bit offset of the addressed lane within the word for the given endianness.
  function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] offset);
    logic [1:0] lane;
    lane = 2'b00;
    case (size)
      2'b00:   lane = BIG_ENDIAN ? ~offset : offset;
      2'b01:   lane = BIG_ENDIAN ? (offset ^ 2'b10) : offset;
      default: lane = 2'b00;
    endcase
    return {lane, 3'b000};
  endfunction

  always_comb begin
    is_mem    = bus.load | bus.store;
    bad_shape = 1'b0;
    case (bus.size)
      2'b01:   bad_shape = bus.address[0];
      2'b10:   bad_shape = |bus.address[1:0];
      2'b11:   bad_shape = 1'b1;
      default: bad_shape = 1'b0;
    endcase
    illegal = is_mem && ((bus.load && bus.store) || bad_shape);
  end

`ifdef MEM_ACCESS_RANGE_CHECK_EN
  localparam int unsigned RANGE_LSB  = ENTRY_NUM_LOG2 + 2;
  localparam logic [31:0] RANGE_MASK = (RANGE_LSB >= 32) ? 32'd0 : ~((32'd1 << RANGE_LSB) - 32'd1);
  assign out_of_range = |(bus.address & RANGE_MASK);
`else
  // Upper address bits pass through; data_memory wraps them.
  localparam int unsigned unused_entry_num_log2 = ENTRY_NUM_LOG2;
  assign out_of_range = 1'b0;
`endif

  assign bus.range_error = range_flag;

  // Lane extraction for loads and lane replacement for sub-word stores.
  always_comb begin
    shift     = lane_shift(size_q, addr_q[1:0]);
    lane_word = bus.dm_read_data >> shift;
    lane_mask = 32'hFFFF_FFFF;
    load_ext  = lane_word;
    case (size_q)
      2'b00: begin
        lane_mask = 32'h0000_00FF;
        load_ext  = {{24{~uns_q & lane_word[7]}}, lane_word[7:0]};
      end
      2'b01: begin
        lane_mask = 32'h0000_FFFF;
        load_ext  = {{16{~uns_q & lane_word[15]}}, lane_word[15:0]};
      end
      default: begin
        lane_mask = 32'hFFFF_FFFF;
        load_ext  = lane_word;
      end
    endcase
    merged = (bus.dm_read_data & ~(lane_mask << shift)) | ((data_q & lane_mask) << shift);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state          <= IDLE;
      addr_q         <= 32'd0;
      data_q         <= 32'd0;
      size_q         <= 2'b00;
      uns_q          <= 1'b0;
      store_q        <= 1'b0;
      range_flag     <= 1'b0;
      bus.req_ready  <= 1'b1;
      bus.load_data  <= 32'd0;
      bus.load_valid <= 1'b0;
      bus.align_error<= 1'b0;
      bus.error_addr <= 32'd0;
      bus.dm_address <= 32'd0;
      bus.dm_data    <= 32'd0;
      bus.dm_write   <= 1'b0;
      bus.dm_read    <= 1'b0;
    end else begin
      bus.load_valid  <= 1'b0;
      bus.align_error <= 1'b0;
      range_flag      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q  <= bus.address;
            data_q  <= bus.store_data;
            size_q  <= bus.size;
            uns_q   <= bus.load_unsigned;
            store_q <= bus.store;
            if (illegal) begin
              bus.align_error <= 1'b1;
              bus.error_addr  <= bus.address;
            end else if (is_mem && out_of_range) begin
              range_flag     <= 1'b1;
              bus.error_addr <= bus.address;
            end else if (is_mem) begin
              bus.req_ready  <= 1'b0;
              bus.dm_address <= {bus.address[31:2], 2'b00};
              // Only word stores skip the read half of read-modify-write.
              if (bus.store && bus.size == 2'b10) begin
                state        <= WRITE;
                bus.dm_write <= 1'b1;
                bus.dm_data  <= bus.store_data;
              end else begin
                state       <= READ;
                bus.dm_read <= 1'b1;
              end
            end
          end
        end
        READ: begin
          bus.dm_read    <= 1'b0;
          bus.dm_address <= 32'd0;
          state          <= store_q ? MERGE : RESP;
        end
        MERGE: begin
          state          <= WRITE;
          bus.dm_write   <= 1'b1;
          bus.dm_data    <= merged;
          bus.dm_address <= {addr_q[31:2], 2'b00};
        end
        WRITE: begin
          state          <= IDLE;
          bus.dm_write   <= 1'b0;
          bus.dm_data    <= 32'd0;
          bus.dm_address <= 32'd0;
          bus.req_ready  <= 1'b1;
        end
        RESP: begin
          state          <= IDLE;
          bus.load_data  <= load_ext;
          bus.load_valid <= 1'b1;
          bus.req_ready  <= 1'b1;
        end
        default: begin
          state          <= IDLE;
          bus.dm_read    <= 1'b0;
          bus.dm_write   <= 1'b0;
          bus.dm_address <= 32'd0;
          bus.req_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (BIG_ENDIAN=1) with a word-wide memory model.
module tb_mem_access_unit;
`ifdef MEM_ACCESS_RANGE_CHECK_EN
  localparam int unsigned ENL = 3;
`else
  localparam int unsigned ENL = 7;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  int   both_cnt = 0;
  logic [31:0] mem [32];

  always #5 clk = ~clk;

  mem_access_unit_if bus();

  mem_access_unit #(.BIG_ENDIAN(1'b1), .ENTRY_NUM_LOG2(ENL)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  // Synchronous data_memory model: read data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.dm_write) begin
      mem[bus.dm_address[6:2]] <= bus.dm_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.dm_read) begin
      bus.dm_read_data <= mem[bus.dm_address[6:2]];
      rd_cnt <= rd_cnt + 1;
    end
    if (bus.dm_read && bus.dm_write) both_cnt <= both_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for the accepting edge; returns in the cycle after acceptance.
  task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] d);
    bus.req_valid     = 1'b1;
    bus.load          = ld;
    bus.store         = st;
    bus.size          = sz;
    bus.load_unsigned = uns;
    bus.address       = a;
    bus.store_data    = d;
    step();
    bus.req_valid = 1'b0;
    bus.load      = 1'b0;
    bus.store     = 1'b0;
  endtask

  task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                          output int cyc);
    issue(1'b0, 1'b1, sz, 1'b0, a, d);
    cyc = 1;
    while (bus.req_ready !== 1'b1 && cyc < 12) begin
      step();
      cyc++;
    end
  endtask

  // Runs a load and reports whether the read strobe and the cycle-3 valid pulse looked right.
  task automatic do_load(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                         output logic [31:0] data, output logic ok);
    issue(1'b1, 1'b0, sz, uns, a, 32'd0);
    ok = (bus.dm_read === 1'b1) && (bus.dm_address === {a[31:2], 2'b00}) && (bus.req_ready === 1'b0);
    step();
    ok = ok && (bus.load_valid === 1'b0);
    step();
    ok = ok && (bus.load_valid === 1'b1) && (bus.req_ready === 1'b1);
    data = bus.load_data;
    step();
    ok = ok && (bus.load_valid === 1'b0) && (bus.load_data === data);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({bus.req_ready, bus.load_valid, bus.align_error, bus.range_error, bus.dm_read, bus.dm_write,
         bus.load_data, bus.error_addr, bus.dm_address, bus.dm_data} !== {1'b1, 5'b0, 128'd0}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b lv=%b ae=%b re=%b rd=%b wr=%b ld=%h ea=%h da=%h dd=%h exp rdy=1 rest 0",
               bus.req_ready, bus.load_valid, bus.align_error, bus.range_error, bus.dm_read, bus.dm_write,
               bus.load_data, bus.error_addr, bus.dm_address, bus.dm_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_word_store_load();
    logic [31:0] d;
    logic ok;
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h8, 32'h1122_3344);
    checks++;
    if ({bus.dm_write, bus.dm_read, bus.dm_address, bus.dm_data, bus.req_ready} !==
        {1'b1, 1'b0, 32'h8, 32'h1122_3344, 1'b0}) begin
      errors++;
      $display("FAIL sw_write got wr=%b rd=%b a=%h d=%h rdy=%b exp wr=1 rd=0 a=00000008 d=11223344 rdy=0",
               bus.dm_write, bus.dm_read, bus.dm_address, bus.dm_data, bus.req_ready);
    end
    step();
    checks++;
    if ({bus.req_ready, bus.dm_write, bus.dm_address} !== {1'b1, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL sw_ready_c2 got rdy=%b wr=%b a=%h exp rdy=1 wr=0 a=0",
               bus.req_ready, bus.dm_write, bus.dm_address);
    end
    do_load(2'b10, 1'b0, 32'h8, d, ok);
    checks++;
    if ({ok, d} !== {1'b1, 32'h1122_3344}) begin
      errors++;
      $display("FAIL lw_0x8 got ok=%b data=%h exp ok=1 data=11223344", ok, d);
    end
  endtask

  task automatic test_byte_loads();
    logic [31:0] d;
    logic ok;
    int cyc;
    do_store(2'b10, 32'h8, 32'h1122_3344, cyc);
    do_load(2'b00, 1'b1, 32'h9, d, ok);
    checks++;
    if ({ok, d} !== {1'b1, 32'h0000_0022}) begin
      errors++;
      $display("FAIL lbu_0x9 got ok=%b data=%h exp ok=1 data=00000022", ok, d);
    end
    do_load(2'b01, 1'b0, 32'hA, d, ok);
    checks++;
    if ({ok, d} !== {1'b1, 32'h0000_3344}) begin
      errors++;
      $display("FAIL lh_0xA got ok=%b data=%h exp ok=1 data=00003344", ok, d);
    end
    do_store(2'b10, 32'h8, 32'h80FF_0000, cyc);
    do_load(2'b00, 1'b0, 32'h8, d, ok);
    checks++;
    if ({ok, d} !== {1'b1, 32'hFFFF_FF80}) begin
      errors++;
      $display("FAIL lb_0x8 got ok=%b data=%h exp ok=1 data=ffffff80", ok, d);
    end
    do_load(2'b00, 1'b1, 32'h8, d, ok);
    checks++;
    if ({ok, d} !== {1'b1, 32'h0000_0080}) begin
      errors++;
      $display("FAIL lbu_0x8 got ok=%b data=%h exp ok=1 data=00000080", ok, d);
    end
    do_load(2'b01, 1'b0, 32'h8, d, ok);
    checks++;
    if ({ok, d} !== {1'b1, 32'hFFFF_80FF}) begin
      errors++;
      $display("FAIL lh_0x8 got ok=%b data=%h exp ok=1 data=ffff80ff", ok, d);
    end
    do_load(2'b01, 1'b1, 32'h8, d, ok);
    checks++;
    if ({ok, d} !== {1'b1, 32'h0000_80FF}) begin
      errors++;
      $display("FAIL lhu_0x8 got ok=%b data=%h exp ok=1 data=000080ff", ok, d);
    end
    do_load(2'b00, 1'b0, 32'h9, d, ok);
    checks++;
    if ({ok, d} !== {1'b1, 32'hFFFF_FFFF}) begin
      errors++;
      $display("FAIL lb_0x9 got ok=%b data=%h exp ok=1 data=ffffffff", ok, d);
    end
    do_load(2'b00, 1'b0, 32'hB, d, ok);
    checks++;
    if ({ok, d} !== {1'b1, 32'h0000_0000}) begin
      errors++;
      $display("FAIL lb_0xB got ok=%b data=%h exp ok=1 data=00000000", ok, d);
    end
  endtask

  task automatic test_subword_store();
    logic [31:0] d;
    logic ok;
    int cyc;
    do_store(2'b10, 32'h8, 32'h1122_3344, cyc);
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'hA, 32'h0000_BEEF);
    checks++;
    if ({bus.dm_read, bus.dm_write, bus.dm_address} !== {1'b1, 1'b0, 32'h8}) begin
      errors++;
      $display("FAIL sh_read got rd=%b wr=%b a=%h exp rd=1 wr=0 a=00000008",
               bus.dm_read, bus.dm_write, bus.dm_address);
    end
    step();
    checks++;
    if ({bus.dm_read, bus.dm_write, bus.dm_address, bus.req_ready} !== {2'b00, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL sh_merge got rd=%b wr=%b a=%h rdy=%b exp rd=0 wr=0 a=0 rdy=0",
               bus.dm_read, bus.dm_write, bus.dm_address, bus.req_ready);
    end
    step();
    checks++;
    if ({bus.dm_write, bus.dm_read, bus.dm_address, bus.dm_data, bus.req_ready} !==
        {1'b1, 1'b0, 32'h8, 32'h1122_BEEF, 1'b0}) begin
      errors++;
      $display("FAIL sh_write got wr=%b rd=%b a=%h d=%h rdy=%b exp wr=1 rd=0 a=00000008 d=1122beef rdy=0",
               bus.dm_write, bus.dm_read, bus.dm_address, bus.dm_data, bus.req_ready);
    end
    step();
    checks++;
    if ({bus.req_ready, bus.dm_write} !== 2'b10) begin
      errors++;
      $display("FAIL sh_ready_c4 got rdy=%b wr=%b exp rdy=1 wr=0", bus.req_ready, bus.dm_write);
    end
    do_store(2'b00, 32'h8, 32'h0000_00AA, cyc);
    checks++;
    if (cyc !== 4) begin
      errors++;
      $display("FAIL sb_ready_cycle got %0d exp 4", cyc);
    end
    do_load(2'b10, 1'b0, 32'h8, d, ok);
    checks++;
    if ({ok, d} !== {1'b1, 32'hAA22_BEEF}) begin
      errors++;
      $display("FAIL sb_result got ok=%b data=%h exp ok=1 data=aa22beef", ok, d);
    end
    do_store(2'b00, 32'hB, 32'hFFFF_FF55, cyc);
    do_load(2'b10, 1'b0, 32'h8, d, ok);
    checks++;
    if ({ok, d} !== {1'b1, 32'hAA22_BE55}) begin
      errors++;
      $display("FAIL sb_upper_ignored got ok=%b data=%h exp ok=1 data=aa22be55", ok, d);
    end
  endtask

  task automatic test_misalign();
    int rd0;
    int wr0;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h9, 32'd0);
    checks++;
    if ({bus.align_error, bus.range_error, bus.error_addr, bus.req_ready, bus.dm_read, bus.dm_write} !==
        {2'b10, 32'h9, 3'b100}) begin
      errors++;
      $display("FAIL lh_0x9 got ae=%b re=%b ea=%h rdy=%b rd=%b wr=%b exp ae=1 re=0 ea=00000009 rdy=1 rd=0 wr=0",
               bus.align_error, bus.range_error, bus.error_addr, bus.req_ready, bus.dm_read, bus.dm_write);
    end
    step();
    checks++;
    if ({bus.align_error, bus.error_addr} !== {1'b0, 32'h9}) begin
      errors++;
      $display("FAIL align_pulse_hold got ae=%b ea=%h exp ae=0 ea=00000009", bus.align_error, bus.error_addr);
    end
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h6, 32'd0);
    checks++;
    if ({bus.align_error, bus.error_addr, bus.dm_read} !== {1'b1, 32'h6, 1'b0}) begin
      errors++;
      $display("FAIL lw_0x6 got ae=%b ea=%h rd=%b exp ae=1 ea=00000006 rd=0",
               bus.align_error, bus.error_addr, bus.dm_read);
    end
    issue(1'b1, 1'b0, 2'b11, 1'b0, 32'h0, 32'd0);
    checks++;
    if ({bus.align_error, bus.error_addr, bus.dm_read} !== {1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL size11_0x0 got ae=%b ea=%h rd=%b exp ae=1 ea=00000000 rd=0",
               bus.align_error, bus.error_addr, bus.dm_read);
    end
    issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h4, 32'd0);
    checks++;
    if ({bus.align_error, bus.error_addr, bus.dm_read, bus.dm_write} !== {1'b1, 32'h4, 2'b00}) begin
      errors++;
      $display("FAIL ld_and_st got ae=%b ea=%h rd=%b wr=%b exp ae=1 ea=00000004 rd=0 wr=0",
               bus.align_error, bus.error_addr, bus.dm_read, bus.dm_write);
    end
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h3, 32'h1234);
    checks++;
    if ({bus.align_error, bus.error_addr, bus.dm_read, bus.dm_write} !== {1'b1, 32'h3, 2'b00}) begin
      errors++;
      $display("FAIL sh_0x3 got ae=%b ea=%h rd=%b wr=%b exp ae=1 ea=00000003 rd=0 wr=0",
               bus.align_error, bus.error_addr, bus.dm_read, bus.dm_write);
    end
    issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h44, 32'd0);
    checks++;
    if ({bus.align_error, bus.error_addr, bus.req_ready, bus.dm_read, bus.dm_write} !==
        {1'b0, 32'h3, 3'b100}) begin
      errors++;
      $display("FAIL noop got ae=%b ea=%h rdy=%b rd=%b wr=%b exp ae=0 ea=00000003 rdy=1 rd=0 wr=0",
               bus.align_error, bus.error_addr, bus.req_ready, bus.dm_read, bus.dm_write);
    end
    step();
    checks++;
    if ((rd_cnt - rd0) !== 0 || (wr_cnt - wr0) !== 0) begin
      errors++;
      $display("FAIL misalign_no_access got reads=%0d writes=%0d exp 0 0", rd_cnt - rd0, wr_cnt - wr0);
    end
  endtask

  task automatic test_reset_mid_merge();
    logic [31:0] d;
    logic ok;
    int cyc;
    int wr0;
    do_store(2'b10, 32'h0, 32'h5555_AAAA, cyc);
    wr0 = wr_cnt;
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h0, 32'h0000_1234);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({bus.req_ready, bus.dm_write, bus.dm_read} !== 3'b100) begin
      errors++;
      $display("FAIL reset_merge_ready got rdy=%b wr=%b rd=%b exp rdy=1 wr=0 rd=0",
               bus.req_ready, bus.dm_write, bus.dm_read);
    end
    step();
    step();
    checks++;
    if ((wr_cnt - wr0) !== 0) begin
      errors++;
      $display("FAIL reset_merge_no_write got writes=%0d exp 0", wr_cnt - wr0);
    end
    do_load(2'b10, 1'b0, 32'h0, d, ok);
    checks++;
    if ({ok, d} !== {1'b1, 32'h5555_AAAA}) begin
      errors++;
      $display("FAIL reset_merge_mem got ok=%b data=%h exp ok=1 data=5555aaaa", ok, d);
    end
  endtask

  task automatic test_range();
    logic [31:0] d;
    logic ok;
    int cyc;
    int rd0;
    rd0 = rd_cnt;
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0);
`ifdef MEM_ACCESS_RANGE_CHECK_EN
    checks++;
    if ({bus.range_error, bus.align_error, bus.error_addr, bus.req_ready, bus.dm_read} !==
        {2'b10, 32'h20, 2'b10}) begin
      errors++;
      $display("FAIL lw_0x20_range got re=%b ae=%b ea=%h rdy=%b rd=%b exp re=1 ae=0 ea=00000020 rdy=1 rd=0",
               bus.range_error, bus.align_error, bus.error_addr, bus.req_ready, bus.dm_read);
    end
    step();
    checks++;
    if ({bus.range_error, rd_cnt - rd0} !== {1'b0, 32'd0}) begin
      errors++;
      $display("FAIL range_pulse got re=%b reads=%0d exp re=0 reads=0", bus.range_error, rd_cnt - rd0);
    end
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h22, 32'd0);
    checks++;
    if ({bus.align_error, bus.range_error, bus.error_addr} !== {2'b10, 32'h22}) begin
      errors++;
      $display("FAIL align_over_range got ae=%b re=%b ea=%h exp ae=1 re=0 ea=00000022",
               bus.align_error, bus.range_error, bus.error_addr);
    end
    step();
`else
    checks++;
    if ({bus.range_error, bus.dm_read, bus.dm_address} !== {2'b01, 32'h20}) begin
      errors++;
      $display("FAIL lw_0x20_pass got re=%b rd=%b a=%h exp re=0 rd=1 a=00000020",
               bus.range_error, bus.dm_read, bus.dm_address);
    end
    step();
    step();
    step();
`endif
    do_store(2'b10, 32'h1C, 32'hCAFE_F00D, cyc);
    do_load(2'b10, 1'b0, 32'h1C, d, ok);
    checks++;
    if ({ok, d, bus.range_error} !== {1'b1, 32'hCAFE_F00D, 1'b0}) begin
      errors++;
      $display("FAIL lw_0x1C got ok=%b data=%h re=%b exp ok=1 data=cafef00d re=0", ok, d, bus.range_error);
    end
  endtask

  task automatic test_strobe_exclusive();
    checks++;
    if (both_cnt !== 0) begin
      errors++;
      $display("FAIL strobe_overlap got %0d cycles exp 0", both_cnt);
    end
  endtask

  initial begin
    rst               = 1'b1;
    bus.req_valid     = 1'b0;
    bus.load          = 1'b0;
    bus.store         = 1'b0;
    bus.size          = 2'b00;
    bus.load_unsigned = 1'b0;
    bus.address       = 32'd0;
    bus.store_data    = 32'd0;
    #1;
    test_reset();
    test_word_store_load();
    test_byte_loads();
    test_subword_store();
    test_misalign();
    test_reset_mid_merge();
    test_range();
    test_strobe_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
